// File: rtl/axi_fifo_pkg.sv
// Shared types for the FIFO-to-stream adapters: buffer occupancy encoding and depth.
package axi_fifo_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } occ_state_e;

   localparam int RD_BUF_DEPTH = 2;

endpackage

// File: rtl/axi_fifo_rd_stream.sv
// Drains a FIFO read port (one-cycle registered read latency) into a valid/ready stream,
// using a 2-slot buffer and credit-based pops so no beat is ever dropped or duplicated.
module axi_fifo_rd_stream
   import axi_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 64
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  flush_i,
   input  logic                  fifo_empty_i,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
   output logic                  fifo_rd_en_o,
   output logic                  m_valid_o,
   input  logic                  m_ready_i,
   output logic [DATA_WIDTH-1:0] m_data_o,
   output logic [1:0]            occupancy_o
);

   occ_state_e            occ_q, occ_d;
   logic                  inflight_q;
   logic                  head_q, tail_q;
   logic                  fire, push;
   logic [2:0]            credit;
   logic [DATA_WIDTH-1:0] slot_q [RD_BUF_DEPTH];

   assign fire = m_valid_o && m_ready_i;
   assign push = inflight_q;

   // fire implies occ >= 1, so the subtraction cannot wrap
   assign credit       = {1'b0, occ_q} + {2'b0, inflight_q} - {2'b0, fire};
   assign fifo_rd_en_o = !rst_i && !flush_i && !fifo_empty_i && (credit < 3'd2);

   assign m_valid_o   = (occ_q != EMPTY);
   assign m_data_o    = slot_q[head_q];
   assign occupancy_o = occ_q;

   always_comb begin
      occ_d = occ_q;
      case (occ_q)
         EMPTY:   if (push) occ_d = ONE;
         ONE: begin
            if (push && !fire)      occ_d = TWO;
            else if (fire && !push) occ_d = EMPTY;
         end
         TWO:     if (fire && !push) occ_d = ONE;
         default: occ_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         occ_q      <= EMPTY;
         inflight_q <= 1'b0;
         head_q     <= 1'b0;
         tail_q     <= 1'b0;
         for (int i = 0; i < RD_BUF_DEPTH; i++) slot_q[i] <= '0;
      end else if (flush_i) begin
         // slot contents are left in place; only the bookkeeping is cleared
         occ_q      <= EMPTY;
         inflight_q <= 1'b0;
         head_q     <= 1'b0;
         tail_q     <= 1'b0;
      end else begin
         occ_q      <= occ_d;
         inflight_q <= fifo_rd_en_o && !fifo_empty_i;
         if (push) begin
            slot_q[tail_q] <= fifo_rd_data_i;
            tail_q         <= ~tail_q;
         end
         if (fire) head_q <= ~head_q;
      end
   end

   a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
      (push && occ_q == TWO) |-> fire);

   a_stall_stable: assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
      (m_valid_o && !m_ready_i) |=> (m_valid_o && $stable(m_data_o)));

   a_no_pop_in_reset: assert property (@(posedge clk_i)
      rst_i |-> !fifo_rd_en_o);

endmodule

// File: tb/tb_axi_fifo_rd_stream.sv
// Directed bench for axi_fifo_rd_stream with a queue-based FIFO read-port model.
module tb_axi_fifo_rd_stream;

   localparam int DW = 64;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush = 1'b0;
   logic          fifo_empty = 1'b1;
   logic [DW-1:0] rd_data = '0;
   logic          rd_en;
   logic          m_valid;
   logic          m_ready = 1'b0;
   logic [DW-1:0] m_data;
   logic [1:0]    occ;

   logic          gap = 1'b0;
   logic [DW-1:0] fifo_q [$];
   logic [DW-1:0] exp_q [$];
   int            checks = 0;
   int            errors = 0;

   always #5 clk = ~clk;

   axi_fifo_rd_stream #(.DATA_WIDTH(DW)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .flush_i        (flush),
      .fifo_empty_i   (fifo_empty),
      .fifo_rd_data_i (rd_data),
      .fifo_rd_en_o   (rd_en),
      .m_valid_o      (m_valid),
      .m_ready_i      (m_ready),
      .m_data_o       (m_data),
      .occupancy_o    (occ)
   );

   // FIFO read port: registered data one cycle after an accepted pop
   always @(posedge clk)
      if (rd_en && !fifo_empty) rd_data <= fifo_q.pop_front();

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic void upd();
      fifo_empty = (fifo_q.size() == 0) || gap;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
      upd();
   endtask

   initial begin
      int            pops;
      int            loaded;
      int            got;
      logic [DW-1:0] w;

      // reset state with a loaded FIFO and ready high
      upd();
      repeat (3) cyc();
      for (int i = 0; i < 4; i++) fifo_q.push_back(64'h11 + 64'(i));
      upd();
      m_ready = 1'b1;
      #1;
      chk("rst_valid", m_valid, 0);
      chk("rst_data", m_data, 0);
      chk("rst_occ", occ, 0);
      chk("rst_rden", rd_en, 0);

      // first pop in cycle 1, first beat in cycle 3, back-to-back
      cyc();
      rst = 1'b0;
      #1;
      chk("c1_rden", rd_en, 1);
      chk("c1_valid", m_valid, 0);
      cyc(); #1;
      chk("c2_valid", m_valid, 0);
      for (int i = 0; i < 4; i++) begin
         cyc(); #1;
         chk("stream_valid", m_valid, 1);
         chk("stream_data", m_data, 64'h11 + 64'(i));
      end
      cyc(); #1;
      chk("stream_end_valid", m_valid, 0);

      // backpressure: only two pops, head beat held
      m_ready = 1'b0;
      for (int i = 0; i < 5; i++) fifo_q.push_back(64'h21 + 64'(i));
      upd(); #1;
      pops = 0;
      for (int i = 0; i < 6; i++) begin
         if (rd_en && !fifo_empty) pops++;
         cyc(); #1;
      end
      chk("bp_pops", 64'(pops), 2);
      chk("bp_occ", occ, 2);
      chk("bp_data", m_data, 64'h21);
      cyc(); #1;
      chk("bp_data_hold", m_data, 64'h21);
      chk("bp_valid_hold", m_valid, 1);
      m_ready = 1'b1;
      #1;
      chk("bp_resume_rden", rd_en, 1);
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", m_valid, 1);
         chk("bp_beat", m_data, 64'h21 + 64'(i));
         if (i > 0) chk("bp_occ_one", occ, 1);
         cyc(); #1;
      end
      chk("bp_drained_valid", m_valid, 0);
      chk("bp_drained_occ", occ, 0);

      // random ready and FIFO gaps against a scoreboard
      loaded = 0;
      got = 0;
      for (int c = 0; c < 20000 && got < 1000; c++) begin
         if (loaded < 1000 && fifo_q.size() < 3 && $urandom_range(3) != 0) begin
            w = {$urandom(), $urandom()};
            fifo_q.push_back(w);
            exp_q.push_back(w);
            loaded++;
         end
         gap     = ($urandom_range(3) == 0);
         m_ready = 1'($urandom_range(1));
         upd();
         #1;
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) chk("rand_extra", 1, 0);
            else chk("rand_beat", m_data, exp_q.pop_front());
            got++;
         end
         cyc();
      end
      chk("rand_count", 64'(got), 1000);
      gap = 1'b0;
      m_ready = 1'b0;
      upd();
      repeat (3) cyc();
      chk("rand_idle_occ", occ, 0);

      // flush with one buffered and one in-flight beat
      fifo_q.push_back(64'hA0);
      fifo_q.push_back(64'hA1);
      fifo_q.push_back(64'hA2);
      upd(); #1;
      chk("fl_pop0", rd_en, 1);
      cyc(); #1;
      cyc(); #1;
      chk("fl_pre_occ", occ, 1);
      chk("fl_pre_data", m_data, 64'hA0);
      flush = 1'b1;
      #1;
      chk("fl_rden", rd_en, 0);
      cyc();
      flush = 1'b0;
      #1;
      chk("fl_post_occ", occ, 0);
      chk("fl_post_valid", m_valid, 0);
      m_ready = 1'b1;
      #1;
      chk("fl_repop", rd_en, 1);
      cyc(); #1;
      chk("fl_gap_valid", m_valid, 0);
      cyc(); #1;
      chk("fl_next_valid", m_valid, 1);
      chk("fl_next_data", m_data, 64'hA2);
      cyc(); #1;
      chk("fl_end_valid", m_valid, 0);

      // reset mid-stream with a full buffer
      m_ready = 1'b0;
      for (int i = 0; i < 4; i++) fifo_q.push_back(64'hB1 + 64'(i));
      upd(); #1;
      repeat (3) begin cyc(); #1; end
      chk("rs_pre_occ", occ, 2);
      chk("rs_pre_data", m_data, 64'hB1);
      rst = 1'b1;
      #1;
      chk("rs_rden0", rd_en, 0);
      cyc(); #1;
      chk("rs_valid", m_valid, 0);
      chk("rs_data", m_data, 0);
      chk("rs_occ", occ, 0);
      chk("rs_rden1", rd_en, 0);
      cyc(); #1;
      chk("rs_rden2", rd_en, 0);
      rst = 1'b0;
      m_ready = 1'b1;
      #1;
      chk("rs_repop", rd_en, 1);
      cyc(); #1;
      cyc(); #1;
      chk("rs_b3_valid", m_valid, 1);
      chk("rs_b3_data", m_data, 64'hB3);
      cyc(); #1;
      chk("rs_b4_data", m_data, 64'hB4);
      cyc(); #1;
      chk("rs_end_valid", m_valid, 0);
      chk("rs_fifo_left", 64'(fifo_q.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/axi_fifo_rd_stream.md
# axi_fifo_rd_stream

Read-side adapter that drains an asynchronous FIFO's `rd_en`/`rd_data`/`empty` port and presents the data as an AXI-style valid/ready stream in the sink clock domain. It sits between a clock-crossing FIFO's read port and any AXI channel consumer, such as the R or B channel of a master. It absorbs the FIFO's one-cycle registered read latency with a 2-entry buffer, sustains one beat per cycle, and never drops or duplicates data.

## Interface
- `DATA_WIDTH`, 64, width of FIFO data and stream payload.
- `clk_i`  in  1  sink-domain clock; same clock as the FIFO read side.
- `rst_i`  in  1  reset, synchronous, active-high.
- `flush_i`  in  1  discard buffered and in-flight beats.
- `fifo_empty_i`  in  1  FIFO empty flag (registered in FIFO).
- `fifo_rd_data_i`  in  DATA_WIDTH  FIFO read data; valid the cycle after an accepted pop.
- `fifo_rd_en_o`  out  1  FIFO pop request.
- `m_valid_o`  out  1  stream valid.
- `m_ready_i`  in  1  stream ready.
- `m_data_o`  out  DATA_WIDTH  stream payload.
- `occupancy_o`  out  2  buffered beat count, 0..2 (debug).

## Operation
- Pop contract: a pop is accepted in cycle t when `fifo_rd_en_o && !fifo_empty_i`. The popped word is sampled from `fifo_rd_data_i` in cycle t+1.
- `inflight` flag: 1 in cycle t+1 after an accepted pop in cycle t.
- `fire` = `m_valid_o && m_ready_i`.
- Credit rule: `fifo_rd_en_o = !rst_i && !flush_i && !fifo_empty_i && (occ + inflight - fire < 2)`.
  - This path is combinational from `m_ready_i`; that path is intentional.
  - Arithmetic is done in 3 bits with no underflow, because `fire` implies `occ ≥ 1`.
- Buffer: 2-slot circular buffer with 1-bit head and tail pointers. `occ` is encoded as states EMPTY/ONE/TWO.
  - On each edge, `inflight` pushes at tail and `fire` pops at head. Both may happen in the same cycle.
  - Transitions: EMPTY→ONE on push only. ONE→TWO on push without fire. ONE→EMPTY on fire without push. TWO→ONE on fire. Push+fire keeps the state.
  - The credit rule guarantees a push never arrives in TWO without a fire. This is an assertion in simulation.
- `m_valid_o = (occ != 0)`; `m_data_o = slot[head]`. Both come straight from registers; there is no bypass from `fifo_rd_data_i`.
- AXI stability: while `m_valid_o && !m_ready_i`, `m_valid_o` and `m_data_o` hold until fire, flush or reset.
- Flush (`flush_i`=1 in cycle t):
  - `fifo_rd_en_o`=0 in cycle t.
  - A fire in cycle t still counts as delivered.
  - Data arriving in cycle t from a pop in t-1 is discarded.
  - At the edge: occ←0, inflight←0, pointers←0, slots keep their contents.
  - Words still in the FIFO are not affected.
- Reset (`rst_i`=1, sampled on edge):
  - occ=0, inflight=0, pointers=0, slots=0.
  - Same effect mid-transfer as flush, plus data cleared.
  - `fifo_rd_en_o` is held 0 while `rst_i` is high.

## Timing
- Reset values: `m_valid_o`=0, `m_data_o`=0, `occupancy_o`=0, `fifo_rd_en_o`=0.
- Latency: with the buffer empty and `fifo_empty_i` falling in cycle t, the pop is in t, capture happens at the end of t+1, and `m_valid_o` rises in t+2.
- Throughput: 1 beat/cycle sustained with `m_ready_i` held high and the FIFO non-empty.
- Backpressure: with `m_ready_i`=0, at most 2 beats are buffered. Pops stop once occ + inflight = 2. Resuming `m_ready_i` pops again in the same cycle.
- First `fifo_rd_en_o` after reset deassertion: the first cycle with `rst_i`=0 and `fifo_empty_i`=0.

## Structure
- Shared package `axi_fifo_pkg`: `occ_state_e` enum (EMPTY, ONE, TWO) and `localparam int RD_BUF_DEPTH = 2`.
- The storage is a small register array and the control fits in one `always_ff`. No sub-module is needed.
- Optional sub-module `axi_fifo_rd_buf`, holding the 2-slot buffer and pointers, if reused by the write-side adapter later.
- SVA in the module:
  - No push when occ=2 without fire.
  - Valid/data stable under stall.
  - `fifo_rd_en_o`=0 during reset.

## Test plan
- Reset, FIFO model preloaded 0x11..0x14, `m_ready_i`=1 → first `fifo_rd_en_o` in cycle 1 after reset. `m_valid_o` in cycle 3 with 0x11, then 0x12, 0x13, 0x14 on consecutive cycles; `m_valid_o` drops after 0x14.
- FIFO holds 5 words, `m_ready_i`=0 → exactly 2 pops, `occupancy_o`=2, `m_data_o`=first word stable. Raise `m_ready_i` → remaining 3 delivered in order, no gaps after resumption.
- Random `m_ready_i` (50%) and random FIFO empty gaps, 1000 words → scoreboard exact in-order match, no loss or duplicate, no overflow assertion.
- Flush in the cycle after a pop with occ=1 (buffer 0xA0, in-flight 0xA1) → both discarded, next delivered word is 0xA2, `occupancy_o`=0 the cycle after flush.
- `rst_i` asserted mid-stream with occ=2 → next cycle `m_valid_o`=0, `m_data_o`=0, `fifo_rd_en_o`=0 throughout reset. Normal draining resumes after release.
- Fire and push in the same cycle at occ=1 under full rate → `occupancy_o` stays 1 and data order is preserved.
